oflow_conflict_resolve: RTL
===========================

// Module: oflow_conflict_resolve
// PURPOSE
//  Responder side of the score-board conflict-resolve port. After registration it reads each row's
//  (score0,id0)/(score1,id1), finds rows that chose the same prev-frame ID, and demotes the loser
//  to its 2nd choice by writing pointer=1 back. Rows with no usable choice are flagged for new ID.
//  Sits between oflow_registration and ID allocation in the core.
// PARAMETERS
//  MAX_ROWS   `MAX_ROWS_IN_SCORE_BOARD  score-board rows held locally
//  ROW_LEN    `ROW_LEN                  row index width
//  ID_LEN     `ID_LEN                   ID width
//  SCORE_LEN  `SCORE_LEN                score width, unsigned, lower = better
// PORTS
//  clk              in   1            clock
//  reset_N          in   1            synchronous active-high reset (asserted = 1)
//  start_cr         in   1            1-cycle start pulse; ignored unless IDLE
//  first_frame      in   1            frame_num==0; no resolution needed
//  num_of_rows      in   ROW_LEN      valid rows this frame; clamp to MAX_ROWS
//  row_sel_from_cr  out  ROW_LEN      score-board row address (read or pointer write)
//  score_to_cr      in   2*SCORE_LEN  {score0,score1} of addressed row, valid 1 cycle after address
//  id_to_cr         in   2*ID_LEN     {id0,id1} of addressed row, same timing
//  write_to_pointer out  1            1-cycle pointer write strobe
//  data_from_cr     out  1            pointer value written (always 1 on a demotion)
//  resolved_ptr     out  MAX_ROWS     final pointer per row
//  new_id_req       out  MAX_ROWS     row unmatched, needs fresh ID
//  busy             out  1            high from accepted start until done_cr
//  done_cr          out  1            1-cycle completion pulse
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, local table cleared. Reset mid-operation aborts, no further writes.
//  FSM: IDLE -> LOAD -> SCAN <-> DEMOTE -> DONE -> IDLE.
//   IDLE: on start_cr, clear resolved_ptr/new_id_req, busy=1. first_frame or num_of_rows==0 -> DONE next cycle.
//   LOAD: drive row_sel_from_cr = 0..N-1 on consecutive cycles; capture data one cycle later into local
//    table {sel_id=id0, sel_score=score0, alt_id=id1, alt_score=score1, ptr=0, active=1}. N+1 cycles.
//   SCAN: one compare per cycle, r=1..N-1, j=0..r-1. Conflict if active[r]&active[j]&sel_id[r]==sel_id[j].
//    Loser = higher sel_score; equal scores -> higher row index loses. No conflict at last (r,j) -> DONE.
//   DEMOTE (1 cycle): loser ptr==0 -> ptr=1, sel_id/score=alt, write_to_pointer=1, data_from_cr=1,
//    row_sel_from_cr=loser; loser ptr==1 -> active=0, new_id_req[loser]=1, no write. Then SCAN restarts at r=1,j=0.
//  Termination: <=2N demotions; worst case ~2N*N^2/2 scan cycles, no timeout needed.
//  DONE: resolved_ptr valid, done_cr=1 one cycle, busy=0; outputs held until next accepted start.
//  row_sel_from_cr = 0 and write_to_pointer = 0 outside LOAD/DEMOTE. start_cr while busy ignored.
//  Score compare unsigned full SCORE_LEN; IDs compared full ID_LEN (ID 0 not special).
// STRUCTURE
//  oflow_cr_pkg: cr_state_t enum, cr_row_t struct {sel_id,sel_score,alt_id,alt_score,ptr,active}.
//  Sub-module oflow_cr_row_table: MAX_ROWS x cr_row_t register file, 1 write port, 2 async read ports (r,j).
// TESTING
//  T1 N=3: r0(5,10;7,20) r1(5,8;9,30) r2(9,4;5,50) -> one write row0 ptr=1; resolved_ptr=001, new_id_req=000.
//  T2 N=3: r0(5,10;7,20) r1(5,12;9,30) r2(9,4;1,9) -> write row1; then row1 unmatched: ptr=010, new_id_req=010.
//  T3 tie: r0(3,15;4,1) r1(3,15;6,2) -> row1 demoted (write row1), ptr=10, new_id_req=00.
//  T4 first_frame=1, N=8 -> no reads/writes, done_cr 2 cycles after start, outputs 0.
//  T5 reset_N pulsed during SCAN of T1 -> next cycle busy=0, no write; fresh start reproduces T1.
//  T6 start_cr re-pulsed while busy and num_of_rows=MAX_ROWS+3 -> ignored / clamped, single done_cr.

Source files
------------

// File: rtl/oflow_cr_pkg.sv
// Shared types for the score-board conflict-resolve responder:
// FSM state encoding, per-row local table entry and the loser rule.
package oflow_cr_pkg;

  localparam int CR_MAX_ROWS  = 8;
  localparam int CR_ROW_LEN   = 4;
  localparam int CR_ID_LEN    = 8;
  localparam int CR_SCORE_LEN = 8;

  typedef enum logic [2:0] {
    CR_IDLE   = 3'd0,
    CR_LOAD   = 3'd1,
    CR_SCAN   = 3'd2,
    CR_DEMOTE = 3'd3,
    CR_DONE   = 3'd4
  } cr_state_t;

  typedef struct packed {
    logic [CR_ID_LEN-1:0]    sel_id;
    logic [CR_SCORE_LEN-1:0] sel_score;
    logic [CR_ID_LEN-1:0]    alt_id;
    logic [CR_SCORE_LEN-1:0] alt_score;
    logic                    ptr;
    logic                    active;
  } cr_row_t;

  // Row r (the higher index) loses on a worse score or on a tie.
  function automatic logic cr_hi_row_loses(input logic [CR_SCORE_LEN-1:0] score_hi,
                                           input logic [CR_SCORE_LEN-1:0] score_lo);
    return (score_hi >= score_lo);
  endfunction

endpackage

// File: rtl/oflow_cr_row_table.sv
// Local copy of the score-board rows: one write port, two async read ports.
module oflow_cr_row_table
  import oflow_cr_pkg::*;
#(
  parameter int MAX_ROWS = CR_MAX_ROWS,
  parameter int IDX_W    = $clog2(CR_MAX_ROWS)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  cr_row_t          wr_row_i,
  input  logic [IDX_W-1:0] rd_a_idx_i,
  output cr_row_t          rd_a_row_o,
  input  logic [IDX_W-1:0] rd_b_idx_i,
  output cr_row_t          rd_b_row_o
);

  cr_row_t rows_q [MAX_ROWS];

  // Row storage; cleared on reset and at every accepted start.
  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      for (int k = 0; k < MAX_ROWS; k++) begin
        rows_q[k] <= '0;
      end
    end else if (we_i) begin
      rows_q[wr_idx_i] <= wr_row_i;
    end
  end

  assign rd_a_row_o = rows_q[rd_a_idx_i];
  assign rd_b_row_o = rows_q[rd_b_idx_i];

endmodule

// File: rtl/oflow_conflict_resolve.sv
// Conflict-resolve responder: loads the score-board rows, finds rows sharing a
// prev-frame ID, demotes losers to their 2nd choice and flags rows needing a new ID.
module oflow_conflict_resolve
  import oflow_cr_pkg::*;
#(
  parameter int MAX_ROWS  = CR_MAX_ROWS,
  parameter int ROW_LEN   = CR_ROW_LEN,
  parameter int ID_LEN    = CR_ID_LEN,
  parameter int SCORE_LEN = CR_SCORE_LEN
) (
  input  logic                   clk,
  input  logic                   reset_N,
  input  logic                   start_cr,
  input  logic                   first_frame,
  input  logic [ROW_LEN-1:0]     num_of_rows,
  output logic [ROW_LEN-1:0]     row_sel_from_cr,
  input  logic [2*SCORE_LEN-1:0] score_to_cr,
  input  logic [2*ID_LEN-1:0]    id_to_cr,
  output logic                   write_to_pointer,
  output logic                   data_from_cr,
  output logic [MAX_ROWS-1:0]    resolved_ptr,
  output logic [MAX_ROWS-1:0]    new_id_req,
  output logic                   busy,
  output logic                   done_cr
);

  localparam int IDX_W = $clog2(MAX_ROWS);
  localparam logic [ROW_LEN-1:0] ONE   = ROW_LEN'(1);
  localparam logic [ROW_LEN-1:0] ZERO  = ROW_LEN'(0);
  localparam logic [ROW_LEN-1:0] MAX_N = ROW_LEN'(MAX_ROWS);

  cr_state_t             state_q, state_d;
  logic [ROW_LEN-1:0]    n_q, n_d, cnt_q, cnt_d, r_q, r_d, j_q, j_d;
  logic                  loser_r_q, loser_r_d;
  logic [ROW_LEN-1:0]    row_sel_q, row_sel_d;
  logic                  wr_q, wr_d, data_q, data_d, busy_q, busy_d, done_q, done_d;
  logic [MAX_ROWS-1:0]   ptr_q, ptr_d, newid_q, newid_d;

  logic                  tbl_clr_s, tbl_we_s;
  logic [IDX_W-1:0]      tbl_idx_s;
  cr_row_t               tbl_wdata_s, row_r_s, row_j_s, loser_row_s;
  logic                  conflict_s, r_loses_s, last_s;
  logic [ROW_LEN-1:0]    scan_loser_s, demote_idx_s;

  oflow_cr_row_table #(.MAX_ROWS(MAX_ROWS), .IDX_W(IDX_W)) u_table (
    .clk        (clk),
    .rst_i      (reset_N),
    .clr_i      (tbl_clr_s),
    .we_i       (tbl_we_s),
    .wr_idx_i   (tbl_idx_s),
    .wr_row_i   (tbl_wdata_s),
    .rd_a_idx_i (r_q[IDX_W-1:0]),
    .rd_a_row_o (row_r_s),
    .rd_b_idx_i (j_q[IDX_W-1:0]),
    .rd_b_row_o (row_j_s)
  );

  assign conflict_s   = row_r_s.active & row_j_s.active & (row_r_s.sel_id == row_j_s.sel_id);
  assign r_loses_s    = cr_hi_row_loses(row_r_s.sel_score, row_j_s.sel_score);
  assign last_s       = (r_q == n_q - ONE) && (j_q == r_q - ONE);
  assign scan_loser_s = r_loses_s ? r_q : j_q;
  assign demote_idx_s = loser_r_q ? r_q : j_q;
  assign loser_row_s  = loser_r_q ? row_r_s : row_j_s;

  // Next-state, table write and registered-output logic.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    j_d         = j_q;
    loser_r_d   = loser_r_q;
    row_sel_d   = ZERO;
    wr_d        = 1'b0;
    data_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ptr_d       = ptr_q;
    newid_d     = newid_q;
    tbl_clr_s   = 1'b0;
    tbl_we_s    = 1'b0;
    tbl_idx_s   = IDX_W'(0);
    tbl_wdata_s = '0;
    case (state_q)
      CR_IDLE: begin
        if (start_cr) begin
          busy_d    = 1'b1;
          ptr_d     = '0;
          newid_d   = '0;
          tbl_clr_s = 1'b1;
          cnt_d     = ZERO;
          n_d       = (num_of_rows > MAX_N) ? MAX_N : num_of_rows;
          state_d   = (first_frame || (num_of_rows == ZERO)) ? CR_DONE : CR_LOAD;
        end else begin
          state_d = CR_IDLE;
        end
      end
      CR_LOAD: begin
        // Data returned now belongs to the address driven last cycle.
        if (cnt_q != ZERO) begin
          tbl_we_s              = 1'b1;
          tbl_idx_s             = IDX_W'(cnt_q - ONE);
          tbl_wdata_s.sel_id    = id_to_cr[2*ID_LEN-1:ID_LEN];
          tbl_wdata_s.sel_score = score_to_cr[2*SCORE_LEN-1:SCORE_LEN];
          tbl_wdata_s.alt_id    = id_to_cr[ID_LEN-1:0];
          tbl_wdata_s.alt_score = score_to_cr[SCORE_LEN-1:0];
          tbl_wdata_s.ptr       = 1'b0;
          tbl_wdata_s.active    = 1'b1;
        end else begin
          tbl_we_s = 1'b0;
        end
        if (cnt_q == n_q) begin
          r_d     = ONE;
          j_d     = ZERO;
          state_d = (n_q < ROW_LEN'(2)) ? CR_DONE : CR_SCAN;
        end else begin
          cnt_d     = cnt_q + ONE;
          row_sel_d = ((cnt_q + ONE) < n_q) ? (cnt_q + ONE) : ZERO;
        end
      end
      CR_SCAN: begin
        if (conflict_s) begin
          loser_r_d = r_loses_s;
          state_d   = CR_DEMOTE;
          if (!(r_loses_s ? row_r_s.ptr : row_j_s.ptr)) begin
            wr_d      = 1'b1;
            data_d    = 1'b1;
            row_sel_d = scan_loser_s;
          end else begin
            wr_d = 1'b0;
          end
        end else if (last_s) begin
          state_d = CR_DONE;
        end else if ((j_q + ONE) == r_q) begin
          r_d = r_q + ONE;
          j_d = ZERO;
        end else begin
          j_d = j_q + ONE;
        end
      end
      CR_DEMOTE: begin
        tbl_we_s    = 1'b1;
        tbl_idx_s   = demote_idx_s[IDX_W-1:0];
        tbl_wdata_s = loser_row_s;
        if (!loser_row_s.ptr) begin
          tbl_wdata_s.ptr       = 1'b1;
          tbl_wdata_s.sel_id    = loser_row_s.alt_id;
          tbl_wdata_s.sel_score = loser_row_s.alt_score;
          ptr_d[demote_idx_s[IDX_W-1:0]] = 1'b1;
        end else begin
          tbl_wdata_s.active               = 1'b0;
          newid_d[demote_idx_s[IDX_W-1:0]] = 1'b1;
        end
        r_d     = ONE;
        j_d     = ZERO;
        state_d = CR_SCAN;
      end
      CR_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = CR_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = CR_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q   <= CR_IDLE;
      n_q       <= ZERO;
      cnt_q     <= ZERO;
      r_q       <= ZERO;
      j_q       <= ZERO;
      loser_r_q <= 1'b0;
      row_sel_q <= ZERO;
      wr_q      <= 1'b0;
      data_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ptr_q     <= '0;
      newid_q   <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      j_q       <= j_d;
      loser_r_q <= loser_r_d;
      row_sel_q <= row_sel_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ptr_q     <= ptr_d;
      newid_q   <= newid_d;
    end
  end

  assign row_sel_from_cr  = row_sel_q;
  assign write_to_pointer = wr_q;
  assign data_from_cr     = data_q;
  assign resolved_ptr     = ptr_q;
  assign new_id_req       = newid_q;
  assign busy             = busy_q;
  assign done_cr          = done_q;

endmodule
